// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
`timescale 1ns/1ps
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef logic [2:0] lat_cnt_t;

   // Word-index width for a power-of-two storage depth.
   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response and program-load bus between fetch stage and responder.
`timescale 1ns/1ps
interface imem_responder_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  read_enable;
   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] npc;
   logic                  ready;
   logic [DATA_WIDTH-1:0] instruction;
   logic                  valid;
   logic [DATA_WIDTH-1:0] condpc;
   logic                  fault;
   logic                  write_enable;
   logic [DATA_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_instruction;

   modport master (
      output read_enable, pc, npc, write_enable, write_addr, write_instruction,
      input  ready, instruction, valid, condpc, fault
   );

   modport slave (
      input  read_enable, pc, npc, write_enable, write_addr, write_instruction,
      output ready, instruction, valid, condpc, fault
   );
endinterface

// File: rtl/imem_array.sv
// Instruction storage: one synchronous read port, one write port, read-first.
`timescale 1ns/1ps
module imem_array
   import imem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 1024,
   localparam int unsigned AW        = idx_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
      if (rd_en) rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/imem_responder.sv
// Memory-side end of the fetch handshake with fixed-latency responses.
// IMEM_PREFETCH_EN adds a one-entry next-PC prefetch buffer.
`timescale 1ns/1ps
module imem_responder
   import imem_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH   = 32,
   parameter int unsigned          DEPTH        = 1024,
   parameter int unsigned          READ_LATENCY = 2,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR   = DATA_WIDTH'(NOP)
) (
   input logic              clk,
   input logic              reset,
   imem_responder_if.slave  bus
);

   localparam int unsigned AW       = idx_width(DEPTH);
   localparam lat_cnt_t    LAT_LOAD = 3'(READ_LATENCY - 1);

   state_t                state_q, state_d;
   lat_cnt_t              cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d, npc_q, npc_d;
   logic [DATA_WIDTH-1:0] condpc_q, condpc_d, instr_q, instr_d;
   logic                  ready_q, ready_d, valid_q, valid_d, fault_q, fault_d;
   logic                  use_array_q, use_array_d;
   logic                  accept, pf_hit, fill_now, resp_rd, rd_ok, wr_ok;
   logic [AW-1:0]         rd_idx;
   logic [DATA_WIDTH-1:0] rd_data, instr_out;

`ifdef IMEM_PREFETCH_EN
   logic                  pf_valid_q, pf_valid_d, pf_pend_q, pf_pend_d;
   logic [DATA_WIDTH-1:0] pf_tag_q, pf_tag_d, pf_data_q, pf_data_d;
`endif

   function automatic logic addr_ok(input logic [DATA_WIDTH-1:0] a);
      return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == '0);
   endfunction

   imem_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_array (
      .clk     (clk),
      .rd_en   (resp_rd | fill_now),
      .rd_idx  (rd_idx),
      .rd_data (rd_data),
      .wr_en   (wr_ok),
      .wr_idx  (bus.write_addr[AW+1:2]),
      .wr_data (bus.write_instruction)
   );

   // Next-state, latch and response-data selection.
   always_comb begin
      accept      = bus.read_enable & ready_q;
      pf_hit      = 1'b0;
      fill_now    = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_d        = accept ? bus.pc  : pc_q;
      npc_d       = accept ? bus.npc : npc_q;
      fault_d     = fault_q;
      condpc_d    = condpc_q;
      instr_d     = instr_q;
      use_array_d = use_array_q;
      wr_ok       = bus.write_enable & addr_ok(bus.write_addr);
`ifdef IMEM_PREFETCH_EN
      pf_hit      = accept & pf_valid_q & (bus.pc == pf_tag_q);
`endif

      case (state_q)
         IDLE, RESP: begin
            if (!accept) begin
               state_d = IDLE;
            end else if (READ_LATENCY == 1 || pf_hit) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
               cnt_d   = LAT_LOAD;
            end
         end
         WAIT: begin
            if (cnt_q <= 3'd1) state_d = RESP;
            else               cnt_d   = cnt_q - 3'd1;
         end
         default: state_d = IDLE;
      endcase

      rd_ok   = addr_ok(pc_d);
      resp_rd = (state_d == RESP) & rd_ok & ~pf_hit;
      rd_idx  = pc_d[AW+1:2];
      ready_d = (state_d != WAIT);
      valid_d = (state_d == RESP);

      if (state_d == RESP) begin
         fault_d     = ~rd_ok;
         condpc_d    = npc_d;
         use_array_d = resp_rd;
         instr_d     = NOP_INSTR;
`ifdef IMEM_PREFETCH_EN
         if (pf_hit) instr_d = pf_data_q;
`endif
      end

`ifdef IMEM_PREFETCH_EN
      // The fill borrows the read port, so freeze the shown word into instr_q first.
      fill_now = (state_q == RESP) & ~resp_rd & addr_ok(npc_q);
      if (fill_now) rd_idx = npc_q[AW+1:2];
      if (fill_now && state_d != RESP) begin
         instr_d     = instr_out;
         use_array_d = 1'b0;
      end

      pf_valid_d = pf_valid_q;
      pf_pend_d  = fill_now;
      pf_tag_d   = pf_tag_q;
      pf_data_d  = pf_data_q;
      if (pf_pend_q) begin
         pf_valid_d = 1'b1;
         pf_data_d  = rd_data;
      end
      if (fill_now) begin
         pf_valid_d = 1'b0;
         pf_tag_d   = npc_q;
      end
      if (wr_ok && bus.write_addr[AW+1:2] == pf_tag_d[AW+1:2]) begin
         pf_valid_d = 1'b0;
         pf_pend_d  = 1'b0;
      end
`endif
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         pc_q        <= '0;
         npc_q       <= '0;
         ready_q     <= 1'b0;
         valid_q     <= 1'b0;
         fault_q     <= 1'b0;
         condpc_q    <= '0;
         instr_q     <= '0;
         use_array_q <= 1'b0;
`ifdef IMEM_PREFETCH_EN
         pf_valid_q  <= 1'b0;
         pf_pend_q   <= 1'b0;
         pf_tag_q    <= '0;
         pf_data_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pc_q        <= pc_d;
         npc_q       <= npc_d;
         ready_q     <= ready_d;
         valid_q     <= valid_d;
         fault_q     <= fault_d;
         condpc_q    <= condpc_d;
         instr_q     <= instr_d;
         use_array_q <= use_array_d;
`ifdef IMEM_PREFETCH_EN
         pf_valid_q  <= pf_valid_d;
         pf_pend_q   <= pf_pend_d;
         pf_tag_q    <= pf_tag_d;
         pf_data_q   <= pf_data_d;
`endif
      end
   end

   assign instr_out       = use_array_q ? rd_data : instr_q;
   assign bus.instruction = instr_out;
   assign bus.ready       = ready_q;
   assign bus.valid       = valid_q;
   assign bus.condpc      = condpc_q;
   assign bus.fault       = fault_q;

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory-side end of the fetch/memory handshake.
- Accepts fetch requests (pc, npc, read_enable) from the fetch stage. Returns instruction, valid and condpc after a fixed, parameterised latency.
- Owns the instruction storage and a program-load write port.
- Sits between the fetch stage and the instruction store; the fetch stage treats it as a blocking one-outstanding-request target.

Parameters:
- DATA_WIDTH, 32, width of pc, npc, condpc and instruction words
- DEPTH, 1024, number of instruction words; must be a power of two
- READ_LATENCY, 2, cycles from request acceptance to valid; legal range 1..8
- NOP_INSTR, 32'h0000_0013, word returned for misaligned or out-of-range pc

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- read_enable  in  1  fetch request strobe
- pc  in  DATA_WIDTH  byte address to fetch
- npc  in  DATA_WIDTH  next-PC value travelling with the request
- ready  out  1  responder can accept a request this cycle
- instruction  out  DATA_WIDTH  fetched word, qualified by valid
- valid  out  1  one-cycle response strobe
- condpc  out  DATA_WIDTH  npc of the completed request, qualified by valid
- fault  out  1  completed request was misaligned or out of range, qualified by valid
- write_enable  in  1  program-load write strobe
- write_addr  in  DATA_WIDTH  byte address of the load write
- write_instruction  in  DATA_WIDTH  word to store

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - ready=0 while reset is asserted, ready=1 in the first cycle after release.
  - valid=0, fault=0, instruction=0, condpc=0.
  - Storage contents are not cleared.
- FSM states:
  - IDLE: ready=1.
  - WAIT: ready=0; a latency counter counts down.
  - RESP: valid=1 for exactly one cycle; ready=1.
- Accept: read_enable & ready sampled high on a rising edge. pc and npc are latched at that edge. Inputs are ignored whenever ready=0.
- Transitions:
  - IDLE -> WAIT when READ_LATENCY>1; the counter loads READ_LATENCY-1 and decrements each cycle in WAIT.
  - IDLE -> RESP when READ_LATENCY=1.
  - WAIT -> RESP when the counter reaches 0.
  - RESP -> WAIT/RESP on a new accept (back-to-back). RESP -> IDLE otherwise.
- Latency: valid is high in the READ_LATENCY-th cycle after the accept edge. Sustained throughput is one word per READ_LATENCY cycles.
- Word index: latched pc[log2(DEPTH)+1:2].
- Response data:
  - Normal request: instruction = stored word, condpc = latched npc, fault=0.
  - latched pc[1:0]!=0, or latched pc >= 4*DEPTH: instruction=NOP_INSTR, condpc=latched npc, fault=1.
- Outputs instruction, condpc and fault hold their last values when valid=0.
- Storage read is sampled on the edge that enters RESP.
- Write port:
  - Synchronous write on any edge with write_enable=1, independent of FSM state.
  - Misaligned or out-of-range write addresses are dropped silently.
  - A write and a read-sample to the same word on the same edge is read-first: the response carries the old word.
- Reset asserted mid-request: the request is aborted and no valid is produced after release.

Optional Feature:
- IMEM_PREFETCH_EN defined:
  - On each RESP, the responder fetches the word at latched npc into a one-entry prefetch buffer (tag = npc, buffer valid bit).
  - A subsequent accept with pc equal to the buffered tag goes directly to RESP (latency 1) and serves the buffered word.
  - Any write_enable to the tagged word, or a reset, invalidates the buffer.
  - A non-matching pc takes the normal path and refreshes the buffer at its own RESP.
- IMEM_PREFETCH_EN undefined: no buffer exists; latency is always READ_LATENCY.

Decomposition:
- Package imem_pkg:
  - state enum (IDLE, WAIT, RESP)
  - NOP constant
  - latency counter width type (3 bits)
  - address-index width function
- Sub-module imem_array: DEPTH x DATA_WIDTH storage, one synchronous read port and one write port, read-first. The responder instantiates it once; the prefetch buffer lives in the responder.

Test Plan:
- Reset then load words 0x11111111 at 0x0 and 0x22222222 at 0x4; request pc=0x0, npc=0x4 -> valid exactly 2 cycles after accept, instruction=0x11111111, condpc=0x4, fault=0, ready low in between.
- Back-to-back requests pc=0x0 then pc=0x4, the second issued in the RESP cycle -> two valid pulses 2 cycles apart, data 0x11111111 then 0x22222222.
- Request pc=0x2, then pc=0x1000 (DEPTH=1024) -> both return instruction=0x00000013, fault=1.
- write_enable to 0x0 with 0xDEADBEEF on the same edge the pending read of 0x0 samples -> response 0x11111111; the next read of 0x0 -> 0xDEADBEEF.
- reset pulsed low during WAIT -> valid never asserts for that request; ready=1 in the first cycle after release; the next request completes normally.
- With IMEM_PREFETCH_EN: request pc=0x0, npc=0x4, then pc=0x4 -> second valid 1 cycle after accept with 0x22222222. Repeat after writing 0x4 -> normal 2-cycle latency with the new word.
